// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the pwm level-fade blocks: level width, level
// ceiling, step-engine states and a helper to size channel indices.
package pwm_pkg;

   // Level width expected by the pwm i_lvl inputs.
   localparam int LVL_W = 4;

   // Highest representable level; fades saturate at the target, never here.
   localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

   // Step engine states: waiting for a tick, or walking the channels.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } fade_state_t;

   // Bits needed to index n_ch channels (at least one bit).
   function automatic int ch_idx_w(input int n_ch);
      return (n_ch <= 1) ? 1 : $clog2(n_ch);
   endfunction

endpackage

// File: rtl/pwm_fade_ctrl_tick_gen.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV clocks.
// Counter runs 0..TICK_DIV-1; the tick is high while it sits at the top.
module tick_gen #(
   parameter int TICK_DIV = 1000000
) (
   input  logic clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int               CNT_W    = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Count up and wrap to zero after the last value of the period.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Level scheduler for a bank of pwm channels. Target requests land in a
// one-entry slot and commit on the following edge; a shared step engine
// walks the channels once per fade tick and nudges each level one step
// toward its target.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int LVL_W    = pwm_pkg::LVL_W,
   parameter int TICK_DIV = 1000000
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [3:0]            i_req_ch,
   input  logic [LVL_W-1:0]      i_req_lvl,
   input  logic                  i_req_jump,
   output logic [N_CH*LVL_W-1:0] o_lvl,
   output logic [N_CH-1:0]       o_busy,
   output logic [N_CH-1:0]       o_done
);

   localparam int               IDX_W    = ch_idx_w(N_CH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

   fade_state_t      state;
   fade_state_t      state_nx;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nx;
   logic             tick_pend;
   logic             tick_pend_nx;
   logic             step_en;
   logic             tick;

   logic             slot_full;
   logic [3:0]       slot_ch;
   logic [LVL_W-1:0] slot_lvl;
   logic             slot_jump;
   logic             accept;
   logic             commit;

   logic [LVL_W-1:0] cur [N_CH];
   logic [LVL_W-1:0] tgt [N_CH];
   logic [N_CH-1:0]  done_r;

   // One level step toward the target; equal levels stay put, so no wrap.
   function automatic logic [LVL_W-1:0] step_toward(input logic [LVL_W-1:0] c,
                                                    input logic [LVL_W-1:0] t);
      if (c < t) begin
         return c + LVL_W'(1);
      end else if (c > t) begin
         return c - LVL_W'(1);
      end
      return c;
   endfunction

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   // The slot is the only buffering; it is never ready while reset is held.
   assign o_req_ready = ~slot_full & ~i_rst;
   assign accept      = i_req_valid & o_req_ready;
   assign commit      = slot_full & (32'(slot_ch) < N_CH);

   // Capture an accepted request, then empty the slot on the next edge.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         slot_full <= 1'b0;
         slot_ch   <= '0;
         slot_lvl  <= '0;
         slot_jump <= 1'b0;
      end else if (accept) begin
         slot_full <= 1'b1;
         slot_ch   <= i_req_ch;
         slot_lvl  <= i_req_lvl;
         slot_jump <= i_req_jump;
      end else if (slot_full) begin
         slot_full <= 1'b0;
      end
   end

   // Step engine state register: scan position and the single pending tick.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state     <= IDLE;
         idx       <= '0;
         tick_pend <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         tick_pend <= tick_pend_nx;
      end
   end

   // Start a scan on a tick, visit one channel per cycle, remember a tick that arrives mid-scan.
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      tick_pend_nx = tick_pend;
      step_en      = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick || tick_pend) begin
               state_nx     = SCAN;
               idx_nx       = '0;
               tick_pend_nx = 1'b0;
            end
         end
         SCAN: begin
            step_en = 1'b1;
            if (tick) begin
               tick_pend_nx = 1'b1;
            end
            if (idx == IDX_LAST) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + IDX_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = '0;
         end
      endcase
   end

   // Level update: the scan step sees the old target, a commit then overrides the target, and a jump overrides the step.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int k = 0; k < N_CH; k++) begin
            cur[k] <= '0;
            tgt[k] <= '0;
         end
         done_r <= '0;
      end else begin
         done_r <= '0;
         for (int k = 0; k < N_CH; k++) begin
            if (step_en && (idx == IDX_W'(k)) && (cur[k] != tgt[k])
                && !(commit && slot_jump && (slot_ch == 4'(k)))) begin
               cur[k] <= step_toward(cur[k], tgt[k]);
               if (step_toward(cur[k], tgt[k]) == tgt[k]) begin
                  done_r[k] <= 1'b1;
               end
            end
            if (commit && (slot_ch == 4'(k))) begin
               tgt[k] <= slot_lvl;
               if (slot_jump) begin
                  cur[k] <= slot_lvl;
               end
            end
         end
      end
   end

   // Present registered levels packed per channel and flag channels still fading.
   always_comb begin
      o_lvl  = '0;
      o_busy = '0;
      for (int k = 0; k < N_CH; k++) begin
         o_lvl[k*LVL_W +: LVL_W] = cur[k];
         o_busy[k]               = (cur[k] != tgt[k]);
      end
   end

   assign o_done = done_r;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios plus a random
// request stream, all compared cycle by cycle against a behavioural model.
module tb_pwm_fade_ctrl;

   localparam int N_CH     = 4;
   localparam int LVL_W    = 4;
   localparam int TICK_DIV = 4;

   logic                  clk = 1'b0;
   logic                  i_rst = 1'b1;
   logic                  i_req_valid = 1'b0;
   logic                  o_req_ready;
   logic [3:0]            i_req_ch = '0;
   logic [LVL_W-1:0]      i_req_lvl = '0;
   logic                  i_req_jump = 1'b0;
   logic [N_CH*LVL_W-1:0] o_lvl;
   logic [N_CH-1:0]       o_busy;
   logic [N_CH-1:0]       o_done;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: levels, slot contents, scan position (-1 = idle).
   int            mCur [N_CH];
   int            mTgt [N_CH];
   bit [N_CH-1:0] mDone;
   bit            mSlotFull;
   int            mSlotCh;
   int            mSlotLvl;
   bit            mSlotJump;
   int            mCycles;
   int            mPos;
   bit            mPend;

   // Free-running clock.
   always #5 clk = ~clk;

   pwm_fade_ctrl #(
      .N_CH     (N_CH),
      .LVL_W    (LVL_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_ch    (i_req_ch),
      .i_req_lvl   (i_req_lvl),
      .i_req_jump  (i_req_jump),
      .o_lvl       (o_lvl),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge given the inputs held before it.
   task automatic modelEdge(input bit rst, input bit valid, input int ch, input int lvl, input bit jump);
      bit tick;
      int nc;
      if (rst) begin
         for (int k = 0; k < N_CH; k++) begin
            mCur[k] = 0;
            mTgt[k] = 0;
         end
         mDone = '0; mSlotFull = 0; mSlotCh = 0; mSlotLvl = 0; mSlotJump = 0;
         mCycles = 0; mPos = -1; mPend = 0;
         return;
      end
      tick = ((mCycles % TICK_DIV) == TICK_DIV - 1);
      mCycles++;
      mDone = '0;
      if (mPos >= 0 && mCur[mPos] != mTgt[mPos]) begin
         nc = (mCur[mPos] < mTgt[mPos]) ? mCur[mPos] + 1 : mCur[mPos] - 1;
         if (!(mSlotFull && mSlotJump && mSlotCh == mPos)) begin
            mCur[mPos] = nc;
            if (nc == mTgt[mPos]) mDone[mPos] = 1'b1;
         end
      end
      if (mSlotFull) begin
         if (mSlotCh < N_CH) begin
            mTgt[mSlotCh] = mSlotLvl;
            if (mSlotJump) mCur[mSlotCh] = mSlotLvl;
         end
         mSlotFull = 0;
      end else if (valid) begin
         mSlotFull = 1; mSlotCh = ch; mSlotLvl = lvl; mSlotJump = jump;
      end
      if (mPos < 0) begin
         if (tick || mPend) begin
            mPos  = 0;
            mPend = 0;
         end
      end else begin
         if (tick) mPend = 1;
         mPos = (mPos == N_CH - 1) ? -1 : mPos + 1;
      end
   endtask

   function automatic logic [N_CH*LVL_W-1:0] modelLvl();
      logic [N_CH*LVL_W-1:0] v = '0;
      for (int k = 0; k < N_CH; k++) v[k*LVL_W +: LVL_W] = LVL_W'(mCur[k]);
      return v;
   endfunction

   function automatic logic [N_CH-1:0] modelBusy();
      logic [N_CH-1:0] v = '0;
      for (int k = 0; k < N_CH; k++) v[k] = (mCur[k] != mTgt[k]);
      return v;
   endfunction

   // Drive one cycle of inputs, step the model, and compare after the edge.
   task automatic applyStimulus(input bit rst, input bit valid, input int ch, input int lvl, input bit jump);
      i_rst       = rst;
      i_req_valid = valid;
      i_req_ch    = 4'(ch);
      i_req_lvl   = LVL_W'(lvl);
      i_req_jump  = jump;
      modelEdge(rst, valid, ch, lvl, jump);
      @(posedge clk);
      #1;
      checkOutput("lvl", 32'(o_lvl), 32'(modelLvl()));
      checkOutput("busy", 32'(o_busy), 32'(modelBusy()));
      checkOutput("done", 32'(o_done), 32'(mDone));
      checkOutput("ready", 32'(o_req_ready), 32'(!mSlotFull && !rst));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rst_lvl", 32'(o_lvl), 32'h0);
      checkOutput("rst_busy", 32'(o_busy), 32'h0);
      checkOutput("rst_ready_low", 32'(o_req_ready), 32'h0);
      i_rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", 32'(o_req_ready), 32'h1);
   endtask

   initial begin
      int prev, steps, doneCnt, reachCyc, doneCyc, guard;
      bit [7:0] readySeen;
      int sent;

      $display("[TB] reset and idle");
      doReset();
      doneCnt = 0;
      for (int c = 0; c < 100; c++) begin
         applyStimulus(0, 0, 0, 0, 0);
         if (o_done != '0) doneCnt++;
      end
      checkOutput("idle_no_done", 32'(doneCnt), 32'h0);

      $display("[TB] fade up ch1 to 3");
      doReset();
      applyStimulus(0, 1, 1, 3, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("up_busy", 32'(o_busy[1]), 32'h1);
      prev = 0; steps = 0; doneCnt = 0; reachCyc = -1; doneCyc = -2;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(0, 0, 0, 0, 0);
         if (int'(o_lvl[7:4]) != prev) begin
            checkOutput("up_step", 32'(o_lvl[7:4]), 32'(prev + 1));
            prev = int'(o_lvl[7:4]);
            steps++;
            if (prev == 3) reachCyc = c;
         end
         if (o_done[1]) begin
            doneCnt++;
            doneCyc = c;
         end
      end
      checkOutput("up_steps", 32'(steps), 32'd3);
      checkOutput("up_done_cnt", 32'(doneCnt), 32'd1);
      checkOutput("up_done_when", 32'(doneCyc), 32'(reachCyc));
      checkOutput("up_idle", 32'(o_busy[1]), 32'h0);

      $display("[TB] jump ch0 to 15 then fade to 13");
      doReset();
      applyStimulus(0, 1, 0, 15, 1);
      checkOutput("jump_ready_low", 32'(o_req_ready), 32'h0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("jump_lvl", 32'(o_lvl[3:0]), 32'd15);
      checkOutput("jump_no_done", 32'(o_done), 32'h0);
      applyStimulus(0, 1, 0, 13, 0);
      prev = 15; steps = 0; doneCnt = 0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(0, 0, 0, 0, 0);
         if (int'(o_lvl[3:0]) != prev) begin
            checkOutput("down_step", 32'(o_lvl[3:0]), 32'(prev - 1));
            prev = int'(o_lvl[3:0]);
            steps++;
         end
         if (o_done[0]) doneCnt++;
      end
      checkOutput("down_final", 32'(o_lvl[3:0]), 32'd13);
      checkOutput("down_steps", 32'(steps), 32'd2);
      checkOutput("down_done_cnt", 32'(doneCnt), 32'd1);

      $display("[TB] back-to-back handshake");
      doReset();
      sent = 0;
      readySeen = '0;
      for (int c = 0; c < 8; c++) begin
         readySeen[c] = o_req_ready;
         applyStimulus(0, 1, sent, 5 + sent, 1);
         if (readySeen[c]) sent++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("hs_ready_seq", 32'(readySeen), 32'h55);
      checkOutput("hs_targets", 32'(o_lvl), 32'h8765);

      $display("[TB] out-of-range channel");
      doReset();
      applyStimulus(0, 1, 9, 7, 1);
      idle(20);
      checkOutput("bad_ch_lvl", 32'(o_lvl), 32'h0);
      checkOutput("bad_ch_busy", 32'(o_busy), 32'h0);

      $display("[TB] commit collides with scan step");
      doReset();
      applyStimulus(0, 1, 2, 5, 1);
      applyStimulus(0, 0, 0, 0, 0);
      guard = 0;
      while (mPos != 2 && guard < 50) begin
         applyStimulus(0, 0, 0, 0, 0);
         guard++;
      end
      checkOutput("coll_sync_a", 32'(guard < 50), 32'h1);
      applyStimulus(0, 1, 2, 8, 0);
      applyStimulus(0, 0, 0, 0, 0);
      guard = 0;
      while (mPos != 1 && guard < 50) begin
         applyStimulus(0, 0, 0, 0, 0);
         guard++;
      end
      checkOutput("coll_sync_b", 32'(guard < 50), 32'h1);
      applyStimulus(0, 1, 2, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("coll_step", 32'(o_lvl[11:8]), 32'd6);
      checkOutput("coll_busy", 32'(o_busy[2]), 32'h1);
      guard = 0;
      while (o_lvl[11:8] == 4'd6 && guard < 20) begin
         applyStimulus(0, 0, 0, 0, 0);
         guard++;
      end
      checkOutput("coll_back", 32'(o_lvl[11:8]), 32'd5);

      $display("[TB] reset during scan");
      applyStimulus(0, 1, 3, 12, 0);
      idle(12);
      guard = 0;
      while (mPos != 2 && guard < 50) begin
         applyStimulus(0, 0, 0, 0, 0);
         guard++;
      end
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("midrst_lvl", 32'(o_lvl), 32'h0);
      checkOutput("midrst_busy", 32'(o_busy), 32'h0);
      checkOutput("midrst_done", 32'(o_done), 32'h0);
      checkOutput("midrst_ready", 32'(o_req_ready), 32'h0);

      $display("[TB] random request stream");
      doReset();
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(299, 0) == 0),
                       $urandom_range(1, 0) == 1,
                       int'($urandom_range(5, 0)),
                       int'($urandom_range(15, 0)),
                       ($urandom_range(5, 0) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
